vending_machine_param: RTL and testbench
========================================

# vending_machine_param

Parametrised single-product vending controller: configurable price, coin acceptance with rejection, cancel/refund, serial change dispensing, and a stock counter with sold-out and restock. It sits between the coin acceptor front-end (one coin code per cycle) and the dispenser/change-hopper drivers. Outputs are registered Mealy-style: they respond one cycle after the triggering input is sampled.

## Interface
- PRICE, 4, drink price in 0.5-yuan units; legal range 2..(2^CW − 2)
- CW, 4, width of credit/remainder registers; must hold PRICE+1
- SW, 4, width of stock counter
- STOCK_INIT, 8, stock value loaded at reset and on restock; must fit in SW
- clk  in  1  system clock, rising-edge
- rstn  in  1  asynchronous active-low reset
- coin  in  2  00 none, 01 = 0.5 yuan, 10 = 1 yuan, 11 = invalid
- cancel  in  1  refund current credit
- restock  in  1  reload stock counter to STOCK_INIT
- sell  out  1  one-cycle pulse: dispense one drink
- change_05  out  1  one-cycle pulse: eject one 0.5-yuan coin
- change_10  out  1  one-cycle pulse: eject one 1-yuan coin
- coin_rej  out  1  one-cycle pulse: inserted coin returned, not credited
- busy  out  1  high while change is being dispensed
- sold_out  out  1  high while stock == 0
- credit  out  CW  current accepted credit, 0.5-yuan units

## Operation
- States: IDLE (credit accumulation, incl. credit 0) and CHANGE (remainder dispensing).
- Coin value v: 01 → 1, 10 → 2.
- IDLE, valid coin, stock > 0, no cancel:
  - sum = credit + v < PRICE → credit ← sum.
  - sum ≥ PRICE → sell pulse; stock −1; credit ← 0; rem ← sum − PRICE.
  - rem > 0 → CHANGE; rem == 0 → stay IDLE.
- IDLE, coin 11, or any coin while sold_out → coin_rej pulse; credit unchanged.
- IDLE, cancel, credit > 0 → rem ← credit; credit ← 0; go CHANGE; no sell. Any coin in the same cycle gets coin_rej (cancel wins).
- IDLE, cancel, credit == 0 → no effect beyond coin handling above.
- CHANGE, each cycle:
  - rem ≥ 2 → change_10 pulse, rem −2.
  - rem == 1 → change_05 pulse, rem −1.
  - Return to IDLE at the edge that issues the final pulse.
  - Any nonzero coin → coin_rej pulse; cancel ignored.
- Restock (any state) → stock ← STOCK_INIT next edge; overrides a simultaneous sell decrement. Pending credit and rem are unaffected.
- sold_out = (stock == 0), registered alongside stock.
- Arithmetic: credit + v never exceeds PRICE+1, so there is no overflow with CW per parameter rule; rem ≤ PRICE+1.

## Timing
- Reset (async assert, sync-to-clk deassert by system):
  - state IDLE; credit 0; rem 0; stock STOCK_INIT.
  - sell, change_05, change_10, coin_rej, busy all 0.
  - sold_out = (STOCK_INIT == 0).
- Coin/cancel sampled at edge T → sell/coin_rej/credit update visible after edge T (one cycle).
- Vend with change: sell and busy rise after edge T. First change pulse follows after edge T+1. For rem needing k coins, busy stays high k cycles and drops after the edge that asserts the last change pulse. A coin in that last-pulse cycle is accepted.
- Back-to-back purchases: no dead cycle when rem == 0; a coin in the cycle after sell is credited.
- Reset mid-CHANGE aborts dispensing immediately. Outstanding rem is lost by design and stock reloads.
- All pulses are exactly one cycle wide; never more than one of change_05/change_10 is high in a cycle.

## Test plan
- PRICE=4: coins 01,01,01,01 on consecutive cycles → credit 1,2,3; sell pulse one cycle after 4th coin; no change pulses; stock 8→7.
- PRICE=4: coins 10,01,10 → credit 2,3; sell after 3rd; next cycle change_05 once; busy high 1 cycle.
- PRICE=4: coins 10,01 then cancel → change_10 then change_05 on successive cycles; no sell; credit 0; a coin 10 during busy → coin_rej, credit stays 0.
- STOCK_INIT=1: buy with 10,10 → sell, sold_out=1; next coin 01 → coin_rej; restock pulse → sold_out=0, coin 01 → credit 1.
- Coin 11 in IDLE → coin_rej, credit unchanged. Cancel with coin 10 in same cycle at credit 1 → coin_rej plus change_05 refund.
- Reset asserted during CHANGE (PRICE=2, credit 1 + coin 10 → rem 1 pending) → all outputs 0 immediately, credit 0, stock STOCK_INIT; normal purchase works after release.

Source files
------------

// File: rtl/vending_machine_param.sv
// vending_machine_param: single-product vending controller.
// Accepts 0.5/1-yuan coins until PRICE is reached, vends one drink, then
// pays back any overpayment or cancelled credit serially, one coin per cycle.
// All outputs are registered and respond one cycle after the sampled input.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   coin       00 none, 01 = 0.5 yuan, 10 = 1 yuan, 11 = invalid
//   cancel     refund the current credit
//   restock    reload the stock counter to STOCK_INIT
//   sell       one-cycle pulse: dispense one drink
//   change_05  one-cycle pulse: eject one 0.5-yuan coin
//   change_10  one-cycle pulse: eject one 1-yuan coin
//   coin_rej   one-cycle pulse: inserted coin returned
//   busy       high while change is being dispensed
//   sold_out   high while stock == 0
//   credit     accepted credit in 0.5-yuan units
module vending_machine_param #(
   parameter int unsigned PRICE      = 4,
   parameter int unsigned CW         = 4,
   parameter int unsigned SW         = 4,
   parameter int unsigned STOCK_INIT = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [1:0]    coin,
   input  logic          cancel,
   input  logic          restock,
   output logic          sell,
   output logic          change_05,
   output logic          change_10,
   output logic          coin_rej,
   output logic          busy,
   output logic          sold_out,
   output logic [CW-1:0] credit
);

   // One extra bit so credit + coin value can be compared against PRICE.
   localparam logic [CW:0]   PRICE_W = (CW+1)'(PRICE);
   localparam logic [SW-1:0] STOCK_W = SW'(STOCK_INIT);

   typedef enum logic {
      IDLE   = 1'b0,
      CHANGE = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] rem, rem_nxt;
   logic [CW-1:0] credit_nxt;
   logic [SW-1:0] stock, stock_nxt;
   logic          sell_nxt, c05_nxt, c10_nxt, rej_nxt;
   logic          coin_ok;
   logic [CW:0]   coin_val;
   logic [CW:0]   sum;

   // Next-state, datapath and pulse decisions.
   always_comb begin
      state_nxt  = state;
      rem_nxt    = rem;
      credit_nxt = credit;
      stock_nxt  = stock;
      sell_nxt   = 1'b0;
      c05_nxt    = 1'b0;
      c10_nxt    = 1'b0;
      rej_nxt    = 1'b0;

      coin_ok  = (coin == 2'b01) || (coin == 2'b10);
      coin_val = (coin == 2'b10) ? (CW+1)'(2) : (CW+1)'(1);
      sum      = {1'b0, credit} + coin_val;

      case (state)
         IDLE: begin
            if (cancel && (credit != '0)) begin
               // Refund wins over any coin offered in the same cycle.
               rem_nxt    = credit;
               credit_nxt = '0;
               state_nxt  = CHANGE;
               rej_nxt    = (coin != 2'b00);
            end else if ((coin == 2'b11) || ((coin != 2'b00) && sold_out)) begin
               rej_nxt = 1'b1;
            end else if (coin_ok) begin
               if (sum < PRICE_W) begin
                  credit_nxt = sum[CW-1:0];
               end else begin
                  sell_nxt   = 1'b1;
                  stock_nxt  = stock - SW'(1);
                  credit_nxt = '0;
                  rem_nxt    = CW'(sum - PRICE_W);
                  if (sum != PRICE_W) begin
                     state_nxt = CHANGE;
                  end
               end
            end
         end
         CHANGE: begin
            // Cancel is ignored here; coins are bounced.
            rej_nxt = (coin != 2'b00);
            if (rem >= CW'(2)) begin
               c10_nxt = 1'b1;
               rem_nxt = rem - CW'(2);
            end else begin
               c05_nxt = 1'b1;
               rem_nxt = rem - CW'(1);
            end
            // Leave on the edge that issues the final coin.
            if (rem <= CW'(2)) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Restock overrides a same-cycle sell decrement.
      if (restock) begin
         stock_nxt = STOCK_W;
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         rem       <= '0;
         credit    <= '0;
         stock     <= STOCK_W;
         sell      <= 1'b0;
         change_05 <= 1'b0;
         change_10 <= 1'b0;
         coin_rej  <= 1'b0;
         busy      <= 1'b0;
         sold_out  <= (STOCK_W == '0);
      end else begin
         state     <= state_nxt;
         rem       <= rem_nxt;
         credit    <= credit_nxt;
         stock     <= stock_nxt;
         sell      <= sell_nxt;
         change_05 <= c05_nxt;
         change_10 <= c10_nxt;
         coin_rej  <= rej_nxt;
         busy      <= (state_nxt == CHANGE);
         sold_out  <= (stock_nxt == '0);
      end
   end

endmodule

// File: tb/tb_vending_machine_param.sv
// Testbench for vending_machine_param (PRICE=4, STOCK_INIT=8).
// Directed vector table, a reset-during-change sequence, then random
// stimulus checked against a coin-queue reference model.
module tb_vending_machine_param;

   localparam int PRICE      = 4;
   localparam int STOCK_INIT = 8;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [1:0] coin = 2'b00;
   logic       cancel = 1'b0;
   logic       restock = 1'b0;
   logic       sell, change_05, change_10, coin_rej, busy, sold_out;
   logic [3:0] credit;

   vending_machine_param #(
      .PRICE(4), .CW(4), .SW(4), .STOCK_INIT(8)
   ) dut (
      .clk(clk), .rstn(rstn), .coin(coin), .cancel(cancel), .restock(restock),
      .sell(sell), .change_05(change_05), .change_10(change_10),
      .coin_rej(coin_rej), .busy(busy), .sold_out(sold_out), .credit(credit)
   );

   always #5 clk = ~clk;

   // Output vector: {sell, change_05, change_10, coin_rej, busy, sold_out, credit}
   logic [9:0] outv;
   assign outv = {sell, change_05, change_10, coin_rej, busy, sold_out, credit};

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   int m_credit;
   int m_stock;
   int chq[$];          // change coins still owed: 10 or 5
   logic e_sell, e_c05, e_c10, e_rej;

   task automatic model_reset();
      m_credit = 0;
      m_stock  = STOCK_INIT;
      chq.delete();
      e_sell = 0; e_c05 = 0; e_c10 = 0; e_rej = 0;
   endtask

   task automatic refund(input int amt);
      for (int i = 0; i < amt / 2; i++) chq.push_back(10);
      if (amt % 2 != 0) chq.push_back(5);
   endtask

   task automatic step_model(input logic [1:0] c, input logic cn, input logic rs);
      int x;
      e_sell = 0; e_c05 = 0; e_c10 = 0; e_rej = 0;
      if (chq.size() != 0) begin
         x = chq.pop_front();
         if (x == 10) e_c10 = 1; else e_c05 = 1;
         e_rej = (c != 2'b00);
      end else if (cn && m_credit > 0) begin
         refund(m_credit);
         m_credit = 0;
         e_rej = (c != 2'b00);
      end else if (c == 2'b11 || (c != 2'b00 && m_stock == 0)) begin
         e_rej = 1;
      end else if (c != 2'b00) begin
         m_credit += (c == 2'b01) ? 1 : 2;
         if (m_credit >= PRICE) begin
            e_sell = 1;
            m_stock--;
            refund(m_credit - PRICE);
            m_credit = 0;
         end
      end
      if (rs) m_stock = STOCK_INIT;
   endtask

   function automatic logic [9:0] mvec();
      return {e_sell, e_c05, e_c10, e_rej, (chq.size() != 0), (m_stock == 0), 4'(m_credit)};
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (sell c05 c10 rej busy so credit[3:0])",
                  name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] c, input logic cn, input logic rs);
      coin = c; cancel = cn; restock = rs;
      @(posedge clk);
      #1;
      step_model(c, cn, rs);
      coin = 2'b00; cancel = 1'b0; restock = 1'b0;
   endtask

   typedef struct {
      logic [1:0] coin;
      logic       cancel;
      logic       restock;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] c, input logic cn, input logic rs,
                      input logic [5:0] pulses, input int cr);
      vec_t v;
      v.coin = c; v.cancel = cn; v.restock = rs;
      v.exp  = {pulses, 4'(cr)};
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] rc;
      logic       rcn, rrs;

      // pulses field: {sell, c05, c10, rej, busy, sold_out}
      add(2'b01,0,0,6'b000000,1);   // four half-yuan coins
      add(2'b01,0,0,6'b000000,2);
      add(2'b01,0,0,6'b000000,3);
      add(2'b01,0,0,6'b100000,0);   // exact price: sell, no change
      add(2'b10,0,0,6'b000000,2);   // 10,01,10 -> overpay by 1
      add(2'b01,0,0,6'b000000,3);
      add(2'b10,0,0,6'b100010,0);
      add(2'b00,0,0,6'b010000,0);   // change_05, busy drops
      add(2'b10,0,0,6'b000000,2);   // 10,01 then cancel -> refund 3
      add(2'b01,0,0,6'b000000,3);
      add(2'b00,1,0,6'b000010,0);
      add(2'b10,0,0,6'b001110,0);   // coin during change: rejected
      add(2'b00,0,0,6'b010000,0);
      add(2'b11,0,0,6'b000100,0);   // invalid coin
      add(2'b01,0,0,6'b000000,1);
      add(2'b10,1,0,6'b000110,0);   // cancel beats coin
      add(2'b00,0,0,6'b010000,0);
      add(2'b10,0,0,6'b000000,2);   // back-to-back purchase
      add(2'b10,0,0,6'b100000,0);
      add(2'b01,0,0,6'b000000,1);
      add(2'b10,0,0,6'b000000,3);   // coin in last-pulse cycle accepted
      add(2'b10,0,0,6'b100010,0);
      add(2'b00,0,0,6'b010000,0);
      add(2'b01,0,0,6'b000000,1);
      add(2'b10,0,0,6'b000000,3);   // drain stock to zero
      add(2'b01,0,0,6'b100000,0);
      add(2'b10,0,0,6'b000000,2);
      add(2'b10,0,0,6'b100000,0);
      add(2'b10,0,0,6'b000000,2);
      add(2'b10,0,0,6'b100000,0);
      add(2'b10,0,0,6'b000000,2);
      add(2'b10,0,0,6'b100001,0);   // last drink: sold_out
      add(2'b01,0,0,6'b000101,0);   // coin while sold out: rejected
      add(2'b00,0,1,6'b000000,0);   // restock clears sold_out
      add(2'b01,0,0,6'b000000,1);
      add(2'b01,0,0,6'b000000,2);
      add(2'b10,0,1,6'b100000,0);   // sell with restock: stock stays full
      add(2'b00,1,0,6'b000000,0);   // cancel at zero credit: nothing

      model_reset();
      rstn = 1'b0;
      #12;
      check("reset", outv, 10'b0);
      @(negedge clk);
      rstn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].coin, vecs[i].cancel, vecs[i].restock);
         check($sformatf("row%0d", i + 1), outv, vecs[i].exp);
      end

      // Reset while change is pending.
      drive(2'b01,0,0);
      drive(2'b01,0,0);
      drive(2'b01,0,0);
      drive(2'b10,0,0);
      check("pre_reset_vend", outv, 10'b1000100000);
      rstn = 1'b0;
      #2;
      check("reset_mid_change", outv, 10'b0);
      @(posedge clk);
      #1;
      check("reset_held", outv, 10'b0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      drive(2'b10,0,0);
      check("post_reset_coin", outv, {6'b000000, 4'd2});
      drive(2'b10,0,0);
      check("post_reset_sell", outv, {6'b100000, 4'd0});

      // Random stimulus against the model.
      for (int i = 0; i < 600; i++) begin
         rc  = 2'($urandom_range(0, 3));
         rcn = ($urandom_range(0, 7) == 0);
         rrs = ($urandom_range(0, 23) == 0);
         if (rcn && chq.size() == 0 && m_credit == 0) rc = 2'b00;
         drive(rc, rcn, rrs);
         check($sformatf("rand%0d", i), outv, mvec());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
